// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the op encoding used on md_unit.op, the default parameter values,
// and small op-classification helpers used by both md_unit and md_compute.
package md_pkg;

  localparam int unsigned MD_WIDTH       = 32;
  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MSUB  = 4'd8
  } md_op_e;

  // Ops that occupy the unit for a latency window and write HI/LO at the end.
  function automatic logic md_is_timed(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MSUB: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational datapath of the multiply/divide unit.
// Ports:
//   op          : operation code (md_op_e encoding)
//   a, b        : operands rs, rt
//   hi, lo      : current HI/LO (accumulator input for madd/msub)
//   res         : 2*WIDTH result, {hi, lo}; equals {hi, lo} for non-arith ops
//   div_by_zero : div/divu with b == 0; the result must not be committed
module md_compute
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] res,
  output logic               div_by_zero
);

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] s_prod;
  logic [2*WIDTH-1:0] u_prod;
  logic [2*WIDTH-1:0] acc;
  logic               b_zero;
  logic               div_ovf;
  logic [WIDTH-1:0]   sdiv_b;
  logic [WIDTH-1:0]   udiv_b;
  logic signed [WIDTH-1:0] s_a;
  logic signed [WIDTH-1:0] s_b;
  logic signed [WIDTH-1:0] s_q;
  logic signed [WIDTH-1:0] s_r;
  logic [WIDTH-1:0]   u_q;
  logic [WIDTH-1:0]   u_r;

  // Low 2W bits of the product of sign-extended operands are the signed product.
  assign s_prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign u_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign acc    = {hi, lo};

  assign b_zero  = (b == '0);
  assign div_ovf = (a == MIN_INT) && (b == '1);

  // Divisor 1 replaces both the zero divisor (result discarded anyway) and
  // the MIN_INT / -1 overflow case, where a / 1 gives exactly the defined
  // answer: quotient MIN_INT, remainder 0.
  assign sdiv_b = (b_zero || div_ovf) ? ONE : b;
  assign udiv_b = b_zero ? ONE : b;

  assign s_a = a;
  assign s_b = sdiv_b;
  assign s_q = s_a / s_b;
  assign s_r = s_a % s_b;
  assign u_q = a / udiv_b;
  assign u_r = a % udiv_b;

  always_comb begin
    res         = acc;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT:  res = s_prod;
      MD_MULTU: res = u_prod;
      MD_MADD:  res = acc + s_prod;
      MD_MSUB:  res = acc - s_prod;
      MD_DIV: begin
        res         = {s_r, s_q};
        div_by_zero = b_zero;
      end
      MD_DIVU: begin
        res         = {u_r, u_q};
        div_by_zero = b_zero;
      end
      default: res = acc;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// The result is computed at issue into a pending register and committed to
// HI/LO when the latency countdown expires, so a flush or reset during the
// countdown leaves HI/LO at their pre-op values.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start, op  : issue strobe and op code; a/b sampled on the same edge
//   a, b       : operands (a is the mthi/mtlo source)
//   flush      : cancel the in-flight op (also discards a same-cycle start)
//   rd_sel     : rd_data selects HI when 1, LO when 0
//   busy       : op in flight
//   hi, lo     : HI/LO registers
//   rd_data    : combinational HI/LO read mux
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH       = MD_WIDTH,
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             rd_sel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] pend;
  logic               pend_dz;
  logic [2*WIDTH-1:0] res;
  logic               dz;

  md_compute #(
    .WIDTH(WIDTH)
  ) u_compute (
    .op          (op),
    .a           (a),
    .b           (b),
    .hi          (hi),
    .lo          (lo),
    .res         (res),
    .div_by_zero (dz)
  );

  // Priority: reset > flush > countdown (start ignored while busy) > issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend    <= '0;
      pend_dz <= 1'b0;
    end else if (flush) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        busy <= 1'b0;
        if (!pend_dz) begin
          hi <= pend[2*WIDTH-1:WIDTH];
          lo <= pend[WIDTH-1:0];
        end
      end
    end else if (start) begin
      if (md_is_timed(op)) begin
        pend    <= res;
        pend_dz <= dz;
        cnt     <= md_is_div(op) ? DIV_CNT : MULT_CNT;
        busy    <= 1'b1;
      end else if (op == MD_MTHI) begin
        hi <= a;
      end else if (op == MD_MTLO) begin
        lo <= a;
      end
    end
  end

  assign rd_data = rd_sel ? hi : lo;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         rd_sel;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] rd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  md_unit #(
    .WIDTH       (W),
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .rd_sel  (rd_sel),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] pre_hi;
    logic [W-1:0] pre_lo;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    int unsigned  cyc;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge after the sampling edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    op    = OP_NONE;
    a     = '0;
    b     = '0;
  endtask

  // Counts cycles (sampled at negedges) with busy high; bounded.
  task automatic wait_idle(output int unsigned n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic preset(input logic [W-1:0] h, input logic [W-1:0] l);
    issue(OP_MTHI, h, '0);
    chk("mthi.busy", W'(busy), '0);
    issue(OP_MTLO, l, '0);
    chk("mtlo.busy", W'(busy), '0);
    chk("preset.hi", hi, h);
    chk("preset.lo", lo, l);
  endtask

  initial begin
    int unsigned n;
    int unsigned n0;

    vecs = '{
      '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'h0,    32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, MC},
      '{OP_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h0,    32'h0,        32'h00000002, 32'hFFFFFFFA, MC},
      '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h0,    32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, DC},
      '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,    32'h0,        32'h00000000, 32'h80000000, DC},
      '{OP_MADD,  32'h00000002, 32'h00000003, 32'h0,    32'h5,        32'h00000000, 32'h0000000B, MC},
      '{OP_MSUB,  32'h00000004, 32'h00000003, 32'h0,    32'hB,        32'hFFFFFFFF, 32'hFFFFFFFF, MC},
      '{OP_DIVU,  32'h00000010, 32'h00000000, 32'h1234, 32'h5678,     32'h00001234, 32'h00005678, DC},
      '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0,    32'h0,        32'h0000000F, 32'h0FFFFFFF, DC},
      '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h0,    32'h0,        32'h00000001, 32'hFFFFFFFD, DC},
      '{OP_MADD,  32'h00000001, 32'h00000001, 32'h0,    32'hFFFFFFFF, 32'h00000001, 32'h00000000, MC},
      '{OP_MULT,  32'h80000000, 32'h80000000, 32'h0,    32'h0,        32'h40000000, 32'h00000000, MC},
      '{OP_MSUB,  32'hFFFFFFFF, 32'h00000001, 32'h0,    32'h0,        32'h00000000, 32'h00000001, MC},
      '{OP_DIV,   32'h00000005, 32'h00000000, 32'hAAAA, 32'hBBBB,     32'h0000AAAA, 32'h0000BBBB, DC},
      '{OP_MADD,  32'hFFFFFFFF, 32'h00000002, 32'h0,    32'h0,        32'hFFFFFFFF, 32'hFFFFFFFE, MC}
    };

    reset  = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    rd_sel = 1'b0;
    op     = OP_NONE;
    a      = '0;
    b      = '0;
    repeat (2) @(negedge clk);
    chk("reset.busy", W'(busy), '0);
    chk("reset.hi", hi, '0);
    chk("reset.lo", lo, '0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      preset(vecs[i].pre_hi, vecs[i].pre_lo);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(n);
      chk($sformatf("v%0d.cycles", i), W'(n), W'(vecs[i].cyc));
      chk($sformatf("v%0d.hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("v%0d.lo", i), lo, vecs[i].exp_lo);
      rd_sel = 1'b1;
      #1;
      chk($sformatf("v%0d.rd_hi", i), rd_data, vecs[i].exp_hi);
      rd_sel = 1'b0;
      #1;
      chk($sformatf("v%0d.rd_lo", i), rd_data, vecs[i].exp_lo);
      @(negedge clk);
    end

    // Undefined op and op 0 have no effect.
    preset(32'h11, 32'h22);
    issue(4'd9, 32'hFFFF, 32'hFFFF);
    chk("undef.busy", W'(busy), '0);
    chk("undef.hi", hi, 32'h11);
    chk("undef.lo", lo, 32'h22);
    issue(OP_NONE, 32'hFFFF, 32'hFFFF);
    chk("none.busy", W'(busy), '0);
    chk("none.lo", lo, 32'h22);

    // Starts issued while busy are ignored.
    preset(32'h0, 32'h0);
    issue(OP_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    issue(OP_MTLO, 32'hDEAD, '0);
    issue(OP_MULT, 32'd3, 32'd3);
    wait_idle(n);
    chk("busyign.cycles", W'(n + 3), W'(DC));
    chk("busyign.hi", hi, 32'd2);
    chk("busyign.lo", lo, 32'd14);

    // Flush in busy cycle 3: no commit, ever.
    preset(32'h1111, 32'h2222);
    issue(OP_MULT, 32'd5, 32'd5);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush.busy", W'(busy), '0);
    chk("flush.hi", hi, 32'h1111);
    chk("flush.lo", lo, 32'h2222);
    repeat (8) @(negedge clk);
    chk("flush.late_busy", W'(busy), '0);
    chk("flush.late_lo", lo, 32'h2222);

    // Flush together with start discards the start.
    flush = 1'b1;
    issue(OP_MULT, 32'd5, 32'd5);
    flush = 1'b0;
    chk("flushstart.busy", W'(busy), '0);
    repeat (6) @(negedge clk);
    chk("flushstart.hi", hi, 32'h1111);
    chk("flushstart.lo", lo, 32'h2222);

    // Unit still works after a flush.
    issue(OP_MULT, 32'd2, 32'd3);
    wait_idle(n0);
    chk("postflush.cycles", W'(n0), W'(MC));
    chk("postflush.hi", hi, 32'd0);
    chk("postflush.lo", lo, 32'd6);

    // Reset mid-op: all state cleared, no later commit.
    preset(32'h3333, 32'h4444);
    issue(OP_MULT, 32'd5, 32'd5);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid.busy", W'(busy), '0);
    chk("rstmid.hi", hi, '0);
    chk("rstmid.lo", lo, '0);
    repeat (8) @(negedge clk);
    chk("rstmid.late_busy", W'(busy), '0);
    chk("rstmid.late_lo", lo, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit: the multi-cycle companion to the single-cycle combinational ALU in the CPU execute stage.
- Owns the architectural HI/LO registers and executes mult/multu/div/divu/madd/msub/mthi/mtlo.
- Raises busy for a configurable latency so hazard logic can stall mfhi/mflo and any further MD instruction.
- Supports a flush input so an exception or interrupt can cancel an in-flight operation.

Parameters:
WIDTH, 32, operand and HI/LO width (>=8)
MULT_CYCLES, 5, busy cycles for mult/multu/madd/msub (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; clears all state
start  in  1  issue strobe; op/a/b sampled on the same edge
op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 msub; others = none
a  in  WIDTH  operand rs (mthi/mtlo source)
b  in  WIDTH  operand rt
flush  in  1  cancel in-flight op; HI/LO keep pre-op values
rd_sel  in  1  0 selects LO, 1 selects HI on rd_data
busy  out  1  op in flight
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
rd_data  out  WIDTH  combinational mux: rd_sel ? hi : lo

Behaviour:
- Reset (synchronous, active-high): busy=0, hi=0, lo=0, counter=0, pending result cleared. Reset dominates start and flush. Reset mid-operation aborts the operation with no HI/LO write.
- Idle issue (busy=0, start=1) for op 1–4, 7, 8:
  - At that edge, compute the result into pending registers (pend_hi, pend_lo).
  - Load counter with MULT_CYCLES or DIV_CYCLES; busy=1 on the next cycle.
- Countdown: each edge with busy=1 decrements the counter. On the edge where the counter goes 1->0, copy pend into hi/lo and set busy=0.
  - busy is high for exactly N cycles, N = the op's latency.
  - New hi/lo are visible in the first cycle busy is low.
- mthi/mtlo with busy=0: hi<=a (resp. lo<=a) at the sampling edge; busy stays 0.
- start while busy=1: ignored entirely. Hazard logic stalls it upstream; there is no error flag.
- start with op 0 or an undefined op: no effect.
- flush=1 (and reset=0): busy<=0, counter<=0, hi/lo unchanged.
  - flush together with start in the same cycle: the start is also discarded.
- Arithmetic:
  - mult: signed 2W product; hi=upper W bits, lo=lower W bits.
  - multu: unsigned 2W product; same split.
  - madd/msub: {hi,lo} +/- signed a*b, mod 2^(2W). Uses hi/lo values at the issue edge.
  - div: signed, truncated toward zero; lo=quotient, hi=remainder (sign follows dividend).
  - divu: unsigned; lo=quotient, hi=remainder.
  - div with a=MIN_INT, b=-1: lo=MIN_INT, hi=0, no trap.
  - Divide by zero (div/divu): the op runs its full DIV_CYCLES busy time, then hi/lo are left unchanged (architecturally UNPREDICTABLE; this is our defined choice).
- rd_data is purely combinational and does not check busy; stalling is the pipeline's responsibility.

Decomposition:
- Shared package md_pkg: op encoding constants (MD_NONE..MD_MSUB), width localparam defaults.
- Sub-module md_compute: combinational; takes op, a, b, current hi/lo; returns the 2W pending result plus a div_by_zero flag.
- md_unit itself holds the counter, busy, pend and HI/LO registers, and the flush/reset priority logic.

Test Plan:
- Reset, then mult a=FFFFFFFE b=00000003 -> busy high exactly 5 cycles; then hi=FFFFFFFF, lo=FFFFFFFA.
- multu a=FFFFFFFE b=00000003 -> hi=00000002, lo=FFFFFFFA after 5 busy cycles.
- div a=FFFFFFF9(-7) b=2 -> busy 10 cycles; lo=FFFFFFFD, hi=FFFFFFFF. Then div 80000000 / FFFFFFFF -> lo=80000000, hi=0.
- mtlo 5, mthi 0, then madd a=2 b=3 -> lo=0000000B, hi=0. msub a=4 b=3 -> lo=FFFFFFFF, hi=FFFFFFFF.
- divu a=10 b=0 with hi/lo=1234/5678 -> busy 10 cycles, hi/lo unchanged. Second start issued during busy -> ignored.
- mult issued, flush asserted at busy cycle 3 -> busy=0 next cycle, hi/lo keep old values. Same check with reset mid-op -> hi=lo=0.
